// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive path.
package usb_rx_pkg;

  localparam logic [7:0] USB_SYNC_BYTE     = 8'h80;
  localparam int         USB_MAX_PKT_BYTES = 64;

  typedef enum logic [3:0] {
    IDLE          = 4'd0,
    SYNC_RCV      = 4'd1,
    CHECK_SYNC    = 4'd2,
    RCV_DATA      = 4'd3,
    STORE         = 4'd4,
    EOP_CHECK     = 4'd5,
    EOP_DONE      = 4'd6,
    ERR_WAIT_EOP  = 4'd7,
    ERR_WAIT_EDGE = 4'd8,
    ERR_IDLE      = 4'd9
  } rcv_state_t;

endpackage

// File: rtl/usb_rcv_ctrl.sv
// USB receive control: frames packets, validates SYNC, strobes each data
// byte into the RX FIFO and flags framing errors (bad SYNC, EOP mid-byte,
// oversize packet).
module usb_rcv_ctrl
  import usb_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = USB_SYNC_BYTE,
  parameter int         MAX_BYTES = USB_MAX_PKT_BYTES
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic [7:0] byte_cnt
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_BYTES);

  rcv_state_t state;
  rcv_state_t next_state;
  logic       eoe;
  logic       pkt_start;

  // End of packet is only meaningful at a bit sample point.
  assign eoe       = eop && shift_enable;
  assign pkt_start = ((state == IDLE) || (state == ERR_IDLE)) && d_edge;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned
    // and no latch is inferred.
    next_state = state;
    unique case (state)
      IDLE:          if (d_edge) next_state = SYNC_RCV;
      SYNC_RCV: begin
        if (eoe)                next_state = ERR_WAIT_EDGE;
        else if (byte_received) next_state = CHECK_SYNC;
      end
      CHECK_SYNC:    next_state = (rcv_data == SYNC_BYTE) ? RCV_DATA : ERR_WAIT_EOP;
      RCV_DATA: begin
        // eoe wins over a coincident byte_received: a byte cut by EOP is dropped.
        if (eoe)                next_state = ERR_WAIT_EDGE;
        else if (byte_received) next_state = (byte_cnt == MAX_CNT) ? ERR_WAIT_EOP : STORE;
      end
      STORE:         next_state = EOP_CHECK;
      EOP_CHECK: begin
        // A non-EOP sample here is the first bit of the next byte; the bit
        // timer keeps counting it, so just resume data reception.
        if (shift_enable) next_state = eop ? EOP_DONE : RCV_DATA;
      end
      EOP_DONE:      if (d_edge) next_state = IDLE;
      ERR_WAIT_EOP:  if (eoe)    next_state = ERR_WAIT_EDGE;
      ERR_WAIT_EDGE: if (d_edge) next_state = ERR_IDLE;
      ERR_IDLE:      if (d_edge) next_state = SYNC_RCV;
      default:       next_state = IDLE;
    endcase
  end

  // Data byte counter: cleared at packet start, counts each stored byte,
  // saturates at MAX_BYTES and holds after the packet ends.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                   byte_cnt <= 8'd0;
    else if (pkt_start)                           byte_cnt <= 8'd0;
    else if ((state == STORE) && (byte_cnt != MAX_CNT)) byte_cnt <= byte_cnt + 8'd1;
  end

  // Moore output decode from the registered state.
  always_comb begin
    rcving   = (state != IDLE) && (state != ERR_IDLE);
    w_enable = (state == STORE);
    r_error  = (state == ERR_WAIT_EOP) || (state == ERR_WAIT_EDGE) || (state == ERR_IDLE);
  end

endmodule

// File: tb/tb_usb_rcv_ctrl.sv
// Self-checking bench for usb_rcv_ctrl: directed framing cases plus
// randomized packets, with FIFO writes checked by a scoreboard monitor.
module tb_usb_rcv_ctrl;
  import usb_rx_pkg::*;

  localparam int TB_MAX = 4;

  typedef enum int {K_BOUNDARY, K_MID, K_SIM, K_SYNC_ABORT} kind_e;
  typedef struct packed {
    logic [7:0] data;
    logic [7:0] cnt;
  } wr_t;

  logic       clk;
  logic       n_rst;
  logic       d_edge;
  logic       eop;
  logic       shift_enable;
  logic       byte_received;
  logic [7:0] rcv_data;
  logic       rcving;
  logic       w_enable;
  logic       r_error;
  logic [7:0] byte_cnt;

  int         checks;
  int         errors;
  wr_t        exp_q[$];
  wr_t        mon_e;
  logic       prev_br;
  logic [7:0] pkt_data [16];

  usb_rcv_ctrl #(.SYNC_BYTE(USB_SYNC_BYTE), .MAX_BYTES(TB_MAX)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_edge       (d_edge),
    .eop          (eop),
    .shift_enable (shift_enable),
    .byte_received(byte_received),
    .rcv_data     (rcv_data),
    .rcving       (rcving),
    .w_enable     (w_enable),
    .r_error      (r_error),
    .byte_cnt     (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every FIFO write must follow a byte_received by one
  // cycle and match the next expected byte and running count.
  always @(negedge clk) begin
    if (n_rst && w_enable) begin
      check("w_enable_latency", 32'(prev_br), 32'd1);
      check("r_error_during_write", 32'(r_error), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got data 0x%0h expected no write at %0t", rcv_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_data", 32'(rcv_data), 32'(mon_e.data));
        check("wr_cnt", 32'(byte_cnt), 32'(mon_e.cnt));
      end
    end
    prev_br = byte_received;
  end

  // One clock cycle of stimulus; pulses last exactly this cycle.
  task automatic tick(input logic se, input logic br, input logic de);
    shift_enable  = se;
    byte_received = br;
    d_edge        = de;
    @(posedge clk);
    #1;
    shift_enable  = 1'b0;
    byte_received = 1'b0;
    d_edge        = 1'b0;
  endtask

  // One bit period: sample pulse, optional byte_received, noise edge slot, idle.
  task automatic send_bit(input logic b, input logic ev, input logic last, input logic noisy);
    eop = ev;
    tick(1'b1, 1'b0, 1'b0);
    rcv_data = {b, rcv_data[7:1]};
    tick(1'b0, last, 1'b0);
    tick(1'b0, 1'b0, noisy && ($urandom_range(0, 3) == 0));
    tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0, i == 7, 1'b1);
  endtask

  task automatic eop_bit();
    send_bit(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // 8th bit of a byte arriving together with EOP.
  task automatic sim_bit();
    eop = 1'b1;
    tick(1'b1, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
  endtask

  // Packet-level reference: how many data bytes reach the FIFO and whether
  // the packet ends in error.
  task automatic model(input logic [7:0] s, input int n, input kind_e kind,
                       output int nw, output bit err);
    if (kind == K_SYNC_ABORT || s != USB_SYNC_BYTE) begin
      nw = 0; err = 1'b1;
    end else if (n > TB_MAX) begin
      nw = TB_MAX; err = 1'b1;
    end else begin
      nw = n; err = (kind != K_BOUNDARY) || (n == 0);
    end
  endtask

  task automatic run_packet(input logic [7:0] s, input int n, input kind_e kind, input int kbits);
    int  nw;
    bit  err;
    wr_t w;
    model(s, n, kind, nw, err);
    for (int i = 0; i < nw; i++) begin
      w.data = pkt_data[i];
      w.cnt  = 8'(i);
      exp_q.push_back(w);
    end
    tick(1'b0, 1'b0, 1'b1);
    check("rcving_on_start", 32'(rcving), 32'd1);
    check("r_error_on_start", 32'(r_error), 32'd0);
    check("byte_cnt_on_start", 32'(byte_cnt), 32'd0);
    if (kind == K_SYNC_ABORT) begin
      for (int i = 0; i < kbits; i++) send_bit(s[i], 1'b0, 1'b0, 1'b1);
    end else begin
      send_byte(s);
      check("r_error_after_sync", 32'(r_error), 32'(s != USB_SYNC_BYTE));
      for (int i = 0; i < n; i++) send_byte(pkt_data[i]);
    end
    case (kind)
      K_MID: for (int i = 0; i < kbits; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
      K_SIM: begin
        for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
        sim_bit();
      end
      default: ;
    endcase
    eop_bit();
    if (kind != K_SIM) eop_bit();
    check("rcving_before_return", 32'(rcving), 32'd1);
    check("r_error_before_return", 32'(r_error), 32'(err));
    tick(1'b0, 1'b0, 1'b1);
    eop = 1'b0;
    check("rcving_after_return", 32'(rcving), 32'd0);
    check("r_error_after_return", 32'(r_error), 32'(err));
    check("byte_cnt_final", 32'(byte_cnt), 32'(nw));
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t   w;
    kind_e kind;
    int    n;
    logic [7:0] s;
    checks = 0; errors = 0; prev_br = 1'b0;
    n_rst = 1'b0; d_edge = 1'b0; eop = 1'b0; shift_enable = 1'b0;
    byte_received = 1'b0; rcv_data = 8'h00;
    #12;
    check("reset_rcving", 32'(rcving), 32'd0);
    check("reset_w_enable", 32'(w_enable), 32'd0);
    check("reset_r_error", 32'(r_error), 32'd0);
    check("reset_byte_cnt", 32'(byte_cnt), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) tick(1'b0, 1'b0, 1'b0);

    // Good packet.
    pkt_data[0] = 8'hA5; pkt_data[1] = 8'h3C;
    run_packet(USB_SYNC_BYTE, 2, K_BOUNDARY, 0);
    // Bad SYNC with one trailing data byte; next start must clear r_error.
    pkt_data[0] = 8'h5A;
    run_packet(8'h81, 1, K_BOUNDARY, 0);
    // EOP after 4 data bits.
    run_packet(USB_SYNC_BYTE, 0, K_MID, 4);
    // Oversize: one byte past the limit.
    for (int i = 0; i < 5; i++) pkt_data[i] = 8'($urandom);
    run_packet(USB_SYNC_BYTE, 5, K_BOUNDARY, 0);
    // eoe and byte_received together in RCV_DATA.
    run_packet(USB_SYNC_BYTE, 1, K_SIM, 0);
    // EOP before SYNC completes.
    run_packet(USB_SYNC_BYTE, 0, K_SYNC_ABORT, 3);
    // Zero-data packet.
    run_packet(USB_SYNC_BYTE, 0, K_BOUNDARY, 0);

    // Reset during the second data byte.
    pkt_data[0] = 8'h11;
    w.data = 8'h11; w.cnt = 8'd0;
    exp_q.push_back(w);
    tick(1'b0, 1'b0, 1'b1);
    send_byte(USB_SYNC_BYTE);
    send_byte(8'h11);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("async_reset_rcving", 32'(rcving), 32'd0);
    check("async_reset_w_enable", 32'(w_enable), 32'd0);
    check("async_reset_r_error", 32'(r_error), 32'd0);
    check("async_reset_byte_cnt", 32'(byte_cnt), 32'd0);
    check("async_reset_pending", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    eop = 1'b0;
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    pkt_data[0] = 8'hC3; pkt_data[1] = 8'h0F; pkt_data[2] = 8'hF0;
    run_packet(USB_SYNC_BYTE, 3, K_BOUNDARY, 0);

    // Randomized packets.
    for (int p = 0; p < 30; p++) begin
      n = $urandom_range(0, TB_MAX + 2);
      for (int i = 0; i < n; i++) pkt_data[i] = 8'($urandom);
      s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : USB_SYNC_BYTE;
      case ($urandom_range(0, 5))
        0:       kind = K_MID;
        1:       kind = K_SIM;
        2:       kind = K_SYNC_ABORT;
        default: kind = K_BOUNDARY;
      endcase
      if (kind == K_SYNC_ABORT) n = 0;
      run_packet(s, n, kind, $urandom_range(1, 7));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
